decoder_2_to_4_strobed: RTL and testbench

//  Registered binary-to-one-hot line decoder; the receive-side counterpart of the 4-to-2 line encoder.

---
 rtl/decoder_2_to_4_strobed.sv | 101 ++++++++++
 tb/tb_decoder_2_to_4_strobed.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_2_to_4_strobed.sv
// Registered binary-to-one-hot line decoder with valid/ready intake.
// Each accepted code drives its line for 1+HOLD_CYCLES enabled cycles; back-to-back codes switch gaplessly.
module decoder_2_to_4_strobed #(
   parameter int SEL_W       = 2,
   parameter int HOLD_CYCLES = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SEL_W-1:0]        in_code,
   output logic [(2**SEL_W)-1:0]   out_lines,
   output logic                    out_valid,
   output logic                    done
);

   localparam int              OUT_W     = 2**SEL_W;
   localparam logic [7:0]      HOLD_LD   = 8'(HOLD_CYCLES);
   localparam logic [OUT_W-1:0] LINE_BASE = {{(OUT_W-1){1'b0}}, 1'b1};

   typedef enum logic {
      IDLE  = 1'b0,
      DRIVE = 1'b1
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [7:0]         cnt_r;
   logic [7:0]         cnt_nxt_s;
   logic [SEL_W-1:0]   code_r;
   logic [SEL_W-1:0]   code_nxt_s;
   logic               ready_s;
   logic               accept_s;
   logic               out_valid_s;

   // Intake and output decode; rst_n gating keeps in_ready low while reset is held.
   always_comb begin
      ready_s     = rst_n & en & ((state_r == IDLE) | (cnt_r == 8'd0));
      accept_s    = in_valid & ready_s;
      out_valid_s = en & (state_r == DRIVE);
      in_ready    = ready_s;
      out_valid   = out_valid_s;
      done        = out_valid_s & (cnt_r == 8'd0);
      if (out_valid_s) begin
         out_lines = LINE_BASE << code_r;
      end else begin
         out_lines = {OUT_W{1'b0}};
      end
   end

   // Next-state logic; with en low every register holds its value.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      code_nxt_s  = code_r;
      if (en) begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  state_nxt_s = DRIVE;
                  cnt_nxt_s   = HOLD_LD;
                  code_nxt_s  = in_code;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            DRIVE: begin
               if (cnt_r != 8'd0) begin
                  cnt_nxt_s = cnt_r - 8'd1;
               end else if (accept_s) begin
                  cnt_nxt_s  = HOLD_LD;
                  code_nxt_s = in_code;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            default: begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = 8'd0;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State, hold counter and code register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= 8'd0;
         code_r  <= {SEL_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         code_r  <= code_nxt_s;
      end
   end

endmodule

// File: tb/tb_decoder_2_to_4_strobed.sv
// Bench for decoder_2_to_4_strobed: HOLD_CYCLES=0 and HOLD_CYCLES=2 instances on shared stimulus,
// vector table, directed corner sequences and random traffic against a remaining-cycles model.
module tb_decoder_2_to_4_strobed;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       in_valid;
   logic [1:0] in_code;
   logic       rdy0, rdy1, ov0, ov1, dn0, dn1;
   logic [3:0] lines0, lines1;

   int checks;
   int errors;

   // reference: cycles of drive remaining (including the current one) and current code
   int rem_m  [2];
   int code_m [2];
   int hold_m [2];

   decoder_2_to_4_strobed #(.SEL_W(2), .HOLD_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy0),
      .in_code(in_code), .out_lines(lines0), .out_valid(ov0), .done(dn0));

   decoder_2_to_4_strobed #(.SEL_W(2), .HOLD_CYCLES(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy1),
      .in_code(in_code), .out_lines(lines1), .out_valid(ov1), .done(dn1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_models();
      for (int i = 0; i < 2; i++) begin
         logic       v, d, r;
         logic [3:0] l;
         v = rst_n && en && (rem_m[i] > 0);
         d = v && (rem_m[i] == 1);
         r = rst_n && en && (rem_m[i] <= 1);
         l = v ? 4'(1 << code_m[i]) : 4'd0;
         if (i == 0) begin
            chk("m0_lines", {28'd0, lines0}, {28'd0, l});
            chk("m0_valid", {31'd0, ov0}, {31'd0, v});
            chk("m0_done",  {31'd0, dn0}, {31'd0, d});
            chk("m0_ready", {31'd0, rdy0}, {31'd0, r});
         end else begin
            chk("m1_lines", {28'd0, lines1}, {28'd0, l});
            chk("m1_valid", {31'd0, ov1}, {31'd0, v});
            chk("m1_done",  {31'd0, dn1}, {31'd0, d});
            chk("m1_ready", {31'd0, rdy1}, {31'd0, r});
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         rem_m[i]  = 0;
         code_m[i] = 0;
      end
   endtask

   // one clock edge: model advances from the pre-edge inputs, then both DUTs are compared
   task automatic step();
      int nrem [2];
      int ncode [2];
      for (int i = 0; i < 2; i++) begin
         nrem[i]  = rem_m[i];
         ncode[i] = code_m[i];
         if (rst_n && en) begin
            if (in_valid && rem_m[i] <= 1) begin
               nrem[i]  = hold_m[i] + 1;
               ncode[i] = int'(in_code);
            end else if (rem_m[i] > 0) begin
               nrem[i] = rem_m[i] - 1;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         rem_m[i]  = nrem[i];
         code_m[i] = ncode[i];
      end
      check_models();
   endtask

   task automatic chk1(input string name, input logic [3:0] l, input logic d, input logic r);
      chk({name, "_lines"}, {28'd0, lines1}, {28'd0, l});
      chk({name, "_done"},  {31'd0, dn1}, {31'd0, d});
      chk({name, "_ready"}, {31'd0, rdy1}, {31'd0, r});
   endtask

   typedef struct {
      logic       en;
      logic       vld;
      logic [1:0] code;
      logic [3:0] lines;
      logic       ov;
      logic       dn;
      logic       rdy;
   } vec_t;

   vec_t tbl [11];

   initial begin
      checks = 0;
      errors = 0;
      hold_m[0] = 0;
      hold_m[1] = 2;
      model_reset();

      tbl[0]  = '{1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, 1'b1};
      tbl[1]  = '{1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1, 1'b1};
      tbl[2]  = '{1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1, 1'b1};
      tbl[3]  = '{1'b1, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1, 1'b1};
      tbl[4]  = '{1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1, 1'b1};
      tbl[10] = '{1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, 1'b1};

      // reset with a valid code presented
      rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; in_code = 2'd3;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_lines0", {28'd0, lines0}, 32'd0);
      chk("rst_lines1", {28'd0, lines1}, 32'd0);
      chk("rst_ready0", {31'd0, rdy0}, 32'd0);
      chk("rst_ready1", {31'd0, rdy1}, 32'd0);
      rst_n = 1'b1;
      step();
      chk("first_accept", {28'd0, lines0}, 32'h8);
      in_valid = 1'b0;
      repeat (4) step();

      // HOLD=0 vector table
      for (int k = 0; k < 11; k++) begin
         en = tbl[k].en; in_valid = tbl[k].vld; in_code = tbl[k].code;
         step();
         chk($sformatf("tbl%0d_lines", k), {28'd0, lines0}, {28'd0, tbl[k].lines});
         chk($sformatf("tbl%0d_valid", k), {31'd0, ov0}, {31'd0, tbl[k].ov});
         chk($sformatf("tbl%0d_done", k),  {31'd0, dn0}, {31'd0, tbl[k].dn});
         chk($sformatf("tbl%0d_ready", k), {31'd0, rdy0}, {31'd0, tbl[k].rdy});
      end
      en = 1'b1; in_valid = 1'b0;
      repeat (4) step();

      // HOLD=2: single code 2 is exactly 3 cycles wide
      in_valid = 1'b1; in_code = 2'd2;
      step(); chk1("h2_c1", 4'b0100, 1'b0, 1'b0);
      step(); chk1("h2_c2", 4'b0100, 1'b0, 1'b0);
      step(); chk1("h2_c3", 4'b0100, 1'b1, 1'b1);
      in_valid = 1'b0;
      step(); chk1("h2_end", 4'b0000, 1'b0, 1'b1);

      // back-to-back: code 3 offered in code 1's done cycle
      in_valid = 1'b1; in_code = 2'd1;
      step(); chk1("b2b_a1", 4'b0010, 1'b0, 1'b0);
      in_valid = 1'b0;
      step(); chk1("b2b_a2", 4'b0010, 1'b0, 1'b0);
      step(); chk1("b2b_a3", 4'b0010, 1'b1, 1'b1);
      in_valid = 1'b1; in_code = 2'd3;
      step(); chk1("b2b_b1", 4'b1000, 1'b0, 1'b0);
      in_valid = 1'b0;
      step(); chk1("b2b_b2", 4'b1000, 1'b0, 1'b0);
      step(); chk1("b2b_b3", 4'b1000, 1'b1, 1'b1);
      step(); chk1("b2b_end", 4'b0000, 1'b0, 1'b1);

      // enable dropped in the 2nd drive cycle of code 0
      in_valid = 1'b1; in_code = 2'd0;
      step(); chk1("en_c1", 4'b0001, 1'b0, 1'b0);
      in_valid = 1'b0;
      step(); chk1("en_c2", 4'b0001, 1'b0, 1'b0);
      en = 1'b0;
      #1 chk1("en_off", 4'b0000, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         step(); chk1("en_frozen", 4'b0000, 1'b0, 1'b0);
      end
      en = 1'b1;
      #1 chk1("en_resume", 4'b0001, 1'b0, 1'b0);
      step(); chk1("en_last", 4'b0001, 1'b1, 1'b1);
      step(); chk1("en_end", 4'b0000, 1'b0, 1'b1);

      // asynchronous reset in the middle of a drive
      in_valid = 1'b1; in_code = 2'd3;
      step(); chk1("ar_drive", 4'b1000, 1'b0, 1'b0);
      in_valid = 1'b0;
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      chk1("ar_clear", 4'b0000, 1'b0, 1'b0);
      chk("ar_valid", {31'd0, ov1}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk1("ar_idle", 4'b0000, 1'b0, 1'b1);
      in_valid = 1'b1; in_code = 2'd2;
      step(); chk1("ar_reaccept", 4'b0100, 1'b0, 1'b0);

      // random traffic against the model
      for (int k = 0; k < 400; k++) begin
         en       = ($urandom_range(0, 9) != 0);
         in_valid = ($urandom_range(0, 2) != 0);
         in_code  = 2'($urandom_range(0, 3));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
